// File: rtl/norm_5d_pkg.sv
// Shared constants, FSM state encoding and element-slice helpers for the
// CORDIC-based 5-D vector normaliser.
package norm_pkg;

  localparam int unsigned NORM_DIM  = 5;
  localparam int unsigned NORM_DW   = 32;
  localparam int unsigned FRAC_BITS = 20;

  // Q11.20 unity
  localparam logic [NORM_DW-1:0] Q_ONE = 32'h0010_0000;

  typedef logic [NORM_DW-1:0]          elem_t;
  typedef logic [NORM_DIM*NORM_DW-1:0] vec_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    VEC_REQ  = 3'd1,
    VEC_WAIT = 3'd2,
    ROT_REQ  = 3'd3,
    ROT_WAIT = 3'd4,
    DONE     = 3'd5
  } norm_state_t;

  function automatic elem_t get_elem(input vec_t v, input int unsigned idx);
    return v[idx*NORM_DW +: NORM_DW];
  endfunction

  function automatic vec_t set_elem(input vec_t v, input int unsigned idx, input elem_t e);
    vec_t r;
    r = v;
    r[idx*NORM_DW +: NORM_DW] = e;
    return r;
  endfunction

endpackage

// File: rtl/norm_5d.sv
// Normalises a packed Q11.20 vector to unit length using an external CORDIC:
// a chain of vectoring steps builds the norm, reverse rotations of 1.0 rebuild w/||w||.
module norm_5d
  import norm_pkg::*;
#(
  parameter int unsigned DIMENSIONS    = 5,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned CORDIC_WIDTH  = 38,
  parameter int unsigned CORDIC_STAGES = 16,
  parameter int unsigned ANGLE_WIDTH   = 16
) (
  input  logic                             clk,
  input  logic                             nreset,
  input  logic [DIMENSIONS*DATA_WIDTH-1:0] w_in,
  input  logic                             start,
  output logic                             done,
  output logic [DIMENSIONS*DATA_WIDTH-1:0] W_out,
  output logic                             cordic_nrst,
  output logic                             ica_cordic_vec_en,
  output logic signed [DATA_WIDTH-1:0]     ica_cordic_vec_xin,
  output logic signed [DATA_WIDTH-1:0]     ica_cordic_vec_yin,
  output logic                             ica_cordic_vec_angle_calc_en,
  output logic                             ica_cordic_rot1_en,
  output logic signed [DATA_WIDTH-1:0]     ica_cordic_rot1_xin,
  output logic signed [DATA_WIDTH-1:0]     ica_cordic_rot1_yin,
  output logic [CORDIC_STAGES-1:0]         ica_cordic_rot1_microRot_in,
  output logic [1:0]                       ica_cordic_rot1_quad_in,
  output logic                             ica_cordic_rot1_angle_microRot_n,
  output logic                             ica_cordic_rot1_microRot_ext_vld,
  input  logic                             cordic_vec_opvld,
  input  logic [DATA_WIDTH-1:0]            cordic_vec_xout,
  input  logic [CORDIC_STAGES-1:0]         cordic_vec_microRot_out,
  input  logic [1:0]                       cordic_vec_quad_out,
  input  logic                             cordic_vec_microRot_out_start,
  input  logic [ANGLE_WIDTH-1:0]           cordic_vec_angle_out,
  input  logic                             cordic_rot1_opvld,
  input  logic signed [DATA_WIDTH-1:0]     cordic_rot1_xout,
  input  logic signed [DATA_WIDTH-1:0]     cordic_rot1_yout
);

  localparam int unsigned   KW     = $clog2(DIMENSIONS);
  localparam logic [KW-1:0] K_ONE  = KW'(1);
  localparam logic [KW-1:0] K_LAST = KW'(DIMENSIONS - 1);

  norm_state_t                      state;
  logic [KW-1:0]                    k;
  logic                             w_zero;
  logic                             flush;
  logic [DATA_WIDTH-1:0]            w_lat [DIMENSIONS];
  logic [DATA_WIDTH-1:0]            r_mag [DIMENSIONS];
  logic [CORDIC_STAGES-1:0]         micro [DIMENSIONS];
  logic [1:0]                       quad  [DIMENSIONS];
  logic [DATA_WIDTH-1:0]            rot_x_prev;
  logic [DIMENSIONS*DATA_WIDTH-1:0] w_res;
  logic [DIMENSIONS*DATA_WIDTH-1:0] w_res_next;
  logic                             unused_inputs;

  assign unused_inputs = ^{cordic_vec_microRot_out_start, cordic_vec_angle_out,
                           1'(CORDIC_WIDTH % 2)};

  assign done                             = (state == DONE);
  assign cordic_nrst                      = nreset & ~flush;
  assign ica_cordic_vec_angle_calc_en     = 1'b0;
  assign ica_cordic_rot1_angle_microRot_n = 1'b0;
  assign ica_cordic_rot1_yin              = '0;

  // Result vector including the rotation result arriving this cycle; the
  // final rotation also yields element 0 on its x output.
  always_comb begin
    w_res_next = w_res;
    for (int unsigned i = 0; i < DIMENSIONS; i++) begin
      if (KW'(i) == k) w_res_next[i*DATA_WIDTH +: DATA_WIDTH] = cordic_rot1_yout;
    end
    if (k == K_ONE) w_res_next[DATA_WIDTH-1:0] = cordic_rot1_xout;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state                            <= IDLE;
      k                                <= '0;
      w_zero                           <= 1'b0;
      flush                            <= 1'b0;
      W_out                            <= '0;
      w_res                            <= '0;
      rot_x_prev                       <= '0;
      ica_cordic_vec_en                <= 1'b0;
      ica_cordic_vec_xin               <= '0;
      ica_cordic_vec_yin               <= '0;
      ica_cordic_rot1_en               <= 1'b0;
      ica_cordic_rot1_xin              <= '0;
      ica_cordic_rot1_microRot_in      <= '0;
      ica_cordic_rot1_quad_in          <= '0;
      ica_cordic_rot1_microRot_ext_vld <= 1'b0;
      for (int unsigned i = 0; i < DIMENSIONS; i++) begin
        w_lat[i] <= '0;
        r_mag[i] <= '0;
        micro[i] <= '0;
        quad[i]  <= '0;
      end
    end else begin
      flush              <= 1'b0;
      ica_cordic_vec_en  <= 1'b0;
      ica_cordic_rot1_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int unsigned i = 0; i < DIMENSIONS; i++) begin
              w_lat[i] <= w_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
            w_zero <= (w_in == '0);
            k      <= K_ONE;
            flush  <= 1'b1;
            state  <= VEC_REQ;
          end
        end
        VEC_REQ: begin
          ica_cordic_vec_en  <= 1'b1;
          ica_cordic_vec_xin <= (k == K_ONE) ? w_lat[0] : r_mag[k - K_ONE];
          ica_cordic_vec_yin <= w_lat[k];
          state              <= VEC_WAIT;
        end
        VEC_WAIT: begin
          if (cordic_vec_opvld) begin
            r_mag[k] <= cordic_vec_xout;
            micro[k] <= cordic_vec_microRot_out;
            quad[k]  <= cordic_vec_quad_out;
            if (k != K_LAST) begin
              k     <= k + K_ONE;
              state <= VEC_REQ;
            end else if (w_zero) begin
              W_out <= '0;
              state <= DONE;
            end else begin
              state <= ROT_REQ;
            end
          end
        end
        ROT_REQ: begin
          ica_cordic_rot1_en               <= 1'b1;
          ica_cordic_rot1_microRot_ext_vld <= 1'b1;
          ica_cordic_rot1_xin              <= (k == K_LAST) ? DATA_WIDTH'(Q_ONE) : rot_x_prev;
          ica_cordic_rot1_microRot_in      <= micro[k];
          ica_cordic_rot1_quad_in          <= quad[k];
          state                            <= ROT_WAIT;
        end
        ROT_WAIT: begin
          if (cordic_rot1_opvld) begin
            w_res <= w_res_next;
            if (k == K_ONE) begin
              W_out                            <= w_res_next;
              ica_cordic_rot1_microRot_ext_vld <= 1'b0;
              state                            <= DONE;
            end else begin
              rot_x_prev <= cordic_rot1_xout;
              k          <= k - K_ONE;
              state      <= ROT_REQ;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_norm_5d.sv
// Bench for norm_5d: behavioural CORDIC wrapper with fixed latency, scoreboard of
// real-valued w/||w|| expectations compared on each done pulse.
module tb_norm_5d;

  localparam int  DIM   = 5;
  localparam int  DW    = 32;
  localparam int  NS    = 16;
  localparam int  L     = 20;
  localparam int  BOUND = 8 * (L + 3) + 4;
  localparam real TOL   = 1.0 / 4096.0;
  localparam real SCALE = 1048576.0;

  logic                  clk = 1'b0;
  logic                  nreset;
  logic [DIM*DW-1:0]     w_in;
  logic                  start;
  logic                  done;
  logic [DIM*DW-1:0]     W_out;
  logic                  cordic_nrst;
  logic                  vec_en, vec_calc_en, rot_en, rot_mrn, rot_ext_vld;
  logic signed [DW-1:0]  vec_xin, vec_yin, rot_xin, rot_yin;
  logic [NS-1:0]         rot_mr_in;
  logic [1:0]            rot_quad_in;
  logic                  cv_opvld, cr_opvld;
  logic [DW-1:0]         cv_xout;
  logic [NS-1:0]         cv_mr;
  logic [1:0]            cv_q;
  logic signed [DW-1:0]  cr_xout, cr_yout;

  int  n_checks = 0, n_fail = 0;
  int  done_cnt = 0, rot_en_cnt = 0, const_hi = 0;
  int  vstab_err = 0, rstab_err = 0, vov_err = 0, rov_err = 0;
  real exp_q[$];
  real last_exp [DIM];

  always #5 clk = ~clk;

  norm_5d #(
    .DIMENSIONS(DIM), .DATA_WIDTH(DW), .CORDIC_WIDTH(38),
    .CORDIC_STAGES(NS), .ANGLE_WIDTH(16)
  ) dut (
    .clk(clk), .nreset(nreset), .w_in(w_in), .start(start), .done(done), .W_out(W_out),
    .cordic_nrst(cordic_nrst),
    .ica_cordic_vec_en(vec_en), .ica_cordic_vec_xin(vec_xin), .ica_cordic_vec_yin(vec_yin),
    .ica_cordic_vec_angle_calc_en(vec_calc_en),
    .ica_cordic_rot1_en(rot_en), .ica_cordic_rot1_xin(rot_xin), .ica_cordic_rot1_yin(rot_yin),
    .ica_cordic_rot1_microRot_in(rot_mr_in), .ica_cordic_rot1_quad_in(rot_quad_in),
    .ica_cordic_rot1_angle_microRot_n(rot_mrn), .ica_cordic_rot1_microRot_ext_vld(rot_ext_vld),
    .cordic_vec_opvld(cv_opvld), .cordic_vec_xout(cv_xout), .cordic_vec_microRot_out(cv_mr),
    .cordic_vec_quad_out(cv_q), .cordic_vec_microRot_out_start(1'b0),
    .cordic_vec_angle_out(16'h0000),
    .cordic_rot1_opvld(cr_opvld), .cordic_rot1_xout(cr_xout), .cordic_rot1_yout(cr_yout)
  );

  function automatic real q2r(input logic [DW-1:0] v);
    return $itor($signed(v)) / SCALE;
  endfunction

  function automatic logic [DW-1:0] r2q(input real r);
    int v;
    v = $rtoi(r * SCALE + ((r >= 0.0) ? 0.5 : -0.5));
    return DW'(v);
  endfunction

  function automatic logic [DIM*DW-1:0] mk(input real e4, input real e3, input real e2,
                                           input real e1, input real e0);
    return {r2q(e4), r2q(e3), r2q(e2), r2q(e1), r2q(e0)};
  endfunction

  // Vectoring: reflect a negative x into the right half-plane, then record the
  // micro-rotation directions that drive y to zero.
  function automatic void vec_model(input real xi, input real yi, output real mag,
                                    output logic [NS-1:0] mr, output logic [1:0] qd);
    real x, y, xn, p;
    qd  = {1'b0, (xi < 0.0)};
    x   = (xi < 0.0) ? -xi : xi;
    y   = yi;
    mag = $sqrt(xi * xi + yi * yi);
    for (int i = 0; i < NS; i++) begin
      p     = 1.0 / $itor(1 << i);
      mr[i] = (y > 0.0);
      if (y > 0.0) begin xn = x + y * p; y = y - x * p; end
      else         begin xn = x - y * p; y = y + x * p; end
      x = xn;
    end
  endfunction

  function automatic void rot_model(input real xi, input real yi, input logic [NS-1:0] mr,
                                    input logic [1:0] qd, output real xo, output real yo);
    real phi;
    phi = 0.0;
    for (int i = 0; i < NS; i++) begin
      if (mr[i]) phi = phi + $atan(1.0 / $itor(1 << i));
      else       phi = phi - $atan(1.0 / $itor(1 << i));
    end
    xo = xi * $cos(phi) - yi * $sin(phi);
    yo = xi * $sin(phi) + yi * $cos(phi);
    if (qd[0]) xo = -xo;
  endfunction

  always @(posedge clk) begin : vec_wrapper
    real m;
    logic [NS-1:0] mr;
    logic [1:0] qd;
    int cnt;
    logic signed [DW-1:0] sx, sy;
    cv_opvld <= 1'b0;
    if (!cordic_nrst) begin
      cnt = 0;
    end else if (vec_en) begin
      if (cnt != 0) vov_err++;
      vec_model(q2r(vec_xin), q2r(vec_yin), m, mr, qd);
      cv_xout <= r2q(m);
      cv_mr   <= mr;
      cv_q    <= qd;
      sx = vec_xin;
      sy = vec_yin;
      cnt = L;
    end else if (cnt != 0) begin
      if (cnt == 1) begin
        cv_opvld <= 1'b1;
        if (vec_xin != sx || vec_yin != sy) vstab_err++;
      end
      cnt = cnt - 1;
    end
    if (vec_calc_en || rot_mrn) const_hi++;
  end

  always @(posedge clk) begin : rot_wrapper
    real xo, yo;
    int cnt;
    logic signed [DW-1:0] sx;
    logic [NS-1:0] smr;
    logic [1:0] sq;
    cr_opvld <= 1'b0;
    if (!cordic_nrst) begin
      cnt = 0;
    end else if (rot_en) begin
      rot_en_cnt++;
      if (cnt != 0 || !rot_ext_vld) rov_err++;
      rot_model(q2r(rot_xin), q2r(rot_yin), rot_mr_in, rot_quad_in, xo, yo);
      cr_xout <= r2q(xo);
      cr_yout <= r2q(yo);
      sx  = rot_xin;
      smr = rot_mr_in;
      sq  = rot_quad_in;
      cnt = L;
    end else if (cnt != 0) begin
      if (cnt == 1) begin
        cr_opvld <= 1'b1;
        if (rot_xin != sx || rot_mr_in != smr || rot_quad_in != sq) rstab_err++;
      end
      cnt = cnt - 1;
    end
  end

  always @(posedge clk) if (nreset && done) done_cnt++;

  task automatic chk(input string tag, input real act, input real exp, input real tol);
    n_checks++;
    if ((act - exp > tol) || (exp - act > tol)) begin
      n_fail++;
      $display("FAIL %s: got %f want %f (tol %f)", tag, act, exp, tol);
    end
  endtask

  task automatic compare_out();
    real e;
    if (exp_q.size() < DIM) begin
      chk("sb_empty", exp_q.size(), DIM, 0.0);
    end else begin
      for (int i = 0; i < DIM; i++) begin
        e = exp_q.pop_front();
        chk($sformatf("w_out%0d", i), q2r(norm_pkg::get_elem(W_out, i)), e, TOL);
        last_exp[i] = e;
      end
    end
  endtask

  task automatic run_vec(input logic [DIM*DW-1:0] w, input int hold, input bit reassert);
    real nrm, e;
    int cyc, d0, r0;
    nrm = 0.0;
    for (int i = 0; i < DIM; i++) begin
      e = q2r(norm_pkg::get_elem(w, i));
      nrm = nrm + e * e;
    end
    nrm = $sqrt(nrm);
    for (int i = 0; i < DIM; i++)
      exp_q.push_back((nrm == 0.0) ? 0.0 : q2r(norm_pkg::get_elem(w, i)) / nrm);
    d0 = done_cnt;
    r0 = rot_en_cnt;
    @(posedge clk); #1;
    w_in  = w;
    start = 1'b1;
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc >= hold) start = 1'b0;
      if (reassert && (cyc == 60 || cyc == 61)) start = 1'b1;
      if (cyc == 150)
        for (int i = 0; i < DIM; i++)
          chk($sformatf("w_hold%0d", i), q2r(norm_pkg::get_elem(W_out, i)), last_exp[i], TOL);
    end while (!done && cyc < 400);
    start = 1'b0;
    if (done) begin
      chk("latency_ok", (cyc <= BOUND) ? 1.0 : 0.0, 1.0, 0.0);
      compare_out();
      @(negedge clk);
      chk("done_pulse", done, 0.0, 0.0);
    end else begin
      chk("done_timeout", 0.0, 1.0, 0.0);
      repeat (DIM) void'(exp_q.pop_front());
    end
    repeat (reassert ? 220 : 4) @(negedge clk);
    chk("done_count", done_cnt - d0, 1.0, 0.0);
    if (nrm == 0.0) chk("no_rot_en", rot_en_cnt - r0, 0.0, 0.0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    for (int i = 0; i < DIM; i++) last_exp[i] = 0.0;
    nreset = 1'b0;
    start  = 1'b0;
    w_in   = '0;
    repeat (3) @(negedge clk);
    chk("rst_done",   done, 0.0, 0.0);
    chk("rst_wout",   (W_out == '0) ? 1.0 : 0.0, 1.0, 0.0);
    chk("rst_vec_en", vec_en, 0.0, 0.0);
    chk("rst_rot_en", rot_en, 0.0, 0.0);
    chk("rst_nrst",   cordic_nrst, 0.0, 0.0);
    nreset = 1'b1;
    @(negedge clk);
    chk("nrst_high",  cordic_nrst, 1.0, 0.0);

    run_vec(mk(0.0, 0.0, 0.0, 4.0, 3.0), 1, 1'b0);
    run_vec(mk(15.0, 0.0, 1.0, 0.0, 3.0), 1, 1'b0);
    run_vec(mk(3.0, 0.0, -4.0, 20.0, 5.0), 1, 1'b0);
    run_vec(mk(1.0, -2.0, 0.0, 0.5, -5.0), 1, 1'b0);
    run_vec('0, 1, 1'b0);
    run_vec(mk(0.0, 0.0, 0.0, 0.0, -0.01), 1, 1'b0);
    for (int t = 0; t < 3; t++) begin
      logic [DIM*DW-1:0] w;
      for (int i = 0; i < DIM; i++)
        w[i*DW +: DW] = DW'(int'($urandom_range(0, 200 << 20)) - (100 << 20));
      run_vec(w, 1, 1'b0);
    end
    run_vec(mk(-7.0, 2.0, 0.0, 1.0, 2.0), 2, 1'b1);

    // abort mid-run: no completion may be reported afterwards
    d0 = done_cnt;
    @(posedge clk); #1;
    w_in  = mk(2.0, 2.0, 2.0, 2.0, 2.0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (120) @(negedge clk);
    nreset = 1'b0;
    @(negedge clk);
    chk("abort_wout",  (W_out == '0) ? 1.0 : 0.0, 1.0, 0.0);
    chk("abort_done",  done, 0.0, 0.0);
    chk("abort_nrst",  cordic_nrst, 0.0, 0.0);
    chk("abort_rotEn", rot_en, 0.0, 0.0);
    for (int i = 0; i < DIM; i++) last_exp[i] = 0.0;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    repeat (250) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0.0, 0.0);
    run_vec(mk(0.0, 0.0, 0.0, 4.0, 3.0), 1, 1'b0);

    chk("const_zero_out", const_hi,  0.0, 0.0);
    chk("vec_req_stable", vstab_err, 0.0, 0.0);
    chk("rot_req_stable", rstab_err, 0.0, 0.0);
    chk("vec_single_req", vov_err,   0.0, 0.0);
    chk("rot_single_req", rov_err,   0.0, 0.0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
